// File: rtl/dummy_accelerator_pkg.sv
// dummy_accelerator_pkg: shared types and constants for the dummy accelerator result path.
// Holds the result entry layout and the default result queue depth.
package dummy_accelerator_pkg;
  localparam int RESULT_QUEUE_DEPTH = 4;
  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  id;
    logic [4:0]  rd;
  } ResultEntryType;
endpackage

// File: rtl/dummy_result_queue.sv
// dummy_result_queue: in-order result FIFO between the accelerator result port and the XIF result interface.
// Ports:
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   flush_i                    commit-kill, empties the queue (wins over push/pop)
//   valid_i/ready_o, data_i, id_i, rd_i           accelerator result push side
//   valid_o/ready_i, data_o, id_o, rd_o, we_o     XIF result pop side (head entry)
//   count_o                    current occupancy
// Entries are stored as a flat {data, id, rd} vector so WIDTH/ID_WIDTH stay
// free parameters; the layout matches ResultEntryType at the default widths.
module dummy_result_queue
  import dummy_accelerator_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = RESULT_QUEUE_DEPTH,
  parameter int ID_WIDTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       valid_i,
  output logic                       ready_o,
  input  logic [WIDTH-1:0]           data_i,
  input  logic [ID_WIDTH-1:0]        id_i,
  input  logic [4:0]                 rd_i,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [WIDTH-1:0]           data_o,
  output logic [ID_WIDTH-1:0]        id_o,
  output logic [4:0]                 rd_o,
  output logic                       we_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int EW = WIDTH + ID_WIDTH + 5;
  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_q;
  logic push, pop;
  // Handshakes depend on registered occupancy only, so a full queue stays
  // not-ready even in a cycle where the head is being popped.
  assign ready_o = count_q < CW'(DEPTH);
  assign valid_o = count_q != '0;
  assign we_o    = valid_o;
  assign count_o = count_q;
  assign push    = valid_i && ready_o && !flush_i;
  assign pop     = valid_o && ready_i && !flush_i;
  assign {data_o, id_o, rd_o} = mem[rd_ptr];
  // DEPTH is a power of two, so the pointers wrap DEPTH-1 -> 0 by overflow.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      wr_ptr  <= wr_ptr + AW'(push);
      rd_ptr  <= rd_ptr + AW'(pop);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= {data_i, id_i, rd_i};
  end
endmodule

// File: doc/dummy_result_queue.md
DUMMY_RESULT_QUEUE -- requirements
Module: dummy_result_queue

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the result data width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the number of entries; it is a power of two, >= 2.
REQ-003 The block SHALL have parameter ID_WIDTH, default 4, giving the XIF instruction id width.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-005 The block SHALL have the following ports, in this order:
- clk_i  input  1  clock; all state changes on its rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- flush_i  input  1  commit-kill; discards all queued results.
- valid_i  input  1  accelerator result valid.
- ready_o  output  1  queue can accept a result.
- data_i  input  WIDTH  result data.
- id_i  input  ID_WIDTH  instruction id.
- rd_i  input  5  destination register index.
- valid_o  output  1  XIF result_valid.
- ready_i  input  1  XIF result_ready.
- data_o  output  WIDTH  head result data.
- id_o  output  ID_WIDTH  head id.
- rd_o  output  5  head destination register.
- we_o  output  1  register write enable.
- count_o  output  $clog2(DEPTH+1)  current occupancy.

Function
REQ-006 The block SHALL act as an in-order FIFO between the accelerator result port and the XIF result interface, storing {data, id, rd} per entry.
REQ-007 A push SHALL occur in a cycle where valid_i && ready_o && !flush_i.
REQ-008 A pop SHALL occur in a cycle where valid_o && ready_i && !flush_i.
REQ-009 ready_o SHALL equal (count_o < DEPTH).
- The ready_o decision uses registered state only.
- A full queue deasserts ready_o even when a pop occurs in the same cycle.
REQ-010 valid_o SHALL equal (count_o != 0).
- data_o, id_o and rd_o SHALL present the head entry.
- There is no fall-through: a pushed entry is visible on valid_o at the earliest in the cycle after the push.
REQ-011 we_o SHALL equal valid_o.
REQ-012 While valid_o && !ready_i, data_o, id_o and rd_o SHALL remain stable until the pop or a flush.
REQ-013 On a simultaneous push and pop, count_o SHALL be unchanged, both pointers SHALL advance, and the popped entry SHALL be the old head.
REQ-014 The write and read pointers SHALL wrap from DEPTH-1 to 0.
REQ-015 count_o SHALL increment on push-only and decrement on pop-only; it never exceeds DEPTH and never underflows.
REQ-016 flush_i SHALL take priority over push and pop:
- In the cycle after flush_i is high, count_o = 0, both pointers = 0, and valid_o = 0.
- A push or pop presented in the flush cycle is discarded.
REQ-017 With valid_o low, data_o, id_o and rd_o SHALL be don't-care; implementations drive the stale head entry, which verification does not check.

Reset
REQ-018 Asserting rst_ni low SHALL immediately force:
- count_o = 0, valid_o = 0, we_o = 0, ready_o = 1;
- pointers = 0.
REQ-019 Storage array contents SHALL NOT require reset.
REQ-020 A reset during a transfer SHALL discard all entries; the first result after rst_ni rises is stored at index 0.

Structure
REQ-021 The shared package dummy_accelerator_pkg SHALL hold:
- the entry struct type ResultEntryType {data, id, rd};
- the constant RESULT_QUEUE_DEPTH = 4, used as the default for DEPTH.
REQ-022 The block SHALL be a single module with inline storage and pointer/counter logic; no sub-module is instantiated.

Verification
REQ-023 Reset, then push 0xA5A5_0001 with id=3, rd=7 while ready_i=1 -> valid_o=1 the next cycle with data_o=0xA5A5_0001, id_o=3, rd_o=7, we_o=1; count_o returns to 0 after the pop.
REQ-024 With ready_i=0, push 4 entries (ids 0..3) -> count_o=4 and ready_o=0; a 5th valid_i is not accepted; raising ready_i drains ids in order 0,1,2,3.
REQ-025 At count_o=2, push and pop in the same cycle for 6 consecutive cycles -> count_o stays 2, pointer wrap is exercised, and output order matches input order.
REQ-026 At count_o=3, assert flush_i together with valid_i and ready_i -> next cycle count_o=0, valid_o=0, and the flushed-cycle input is never output.
REQ-027 Hold valid_o with ready_i=0 for 5 cycles while pushing new entries -> data_o, id_o and rd_o stay constant.
REQ-028 Assert rst_ni low mid-burst at count_o=2 -> outputs reset immediately; after release, a new push with data 0x0000_00FF appears as the head.
